iir_biquad_seq: RTL and testbench
=================================

# iir_biquad_seq

- Time-multiplexed, single-multiplier direct-form-I biquad IIR engine.
- Filters one 25-bit Q4.20 sample per request.
- Drives the 3-bit coefficient select of the constant coefficient mux and consumes its coefficient output combinationally in the same cycle.
- Sits between the ADC sample interface and the DAC/output register of the 200 Hz filter channel.

## Interface
- `DW`, 25: sample and coefficient width, signed Q4.20 (1 sign, 4 integer, 20 fraction bits).
- `FRAC`, 20: fraction bits.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sample_valid` input 1: one-cycle request, captures `sample_in`.
- `sample_in` input 25: x[n], signed Q4.20.
- `clear` input 1: synchronous clear of filter history; accepted only in IDLE.
- `sel` output 3: coefficient select to the mux.
- `coef_in` input 26: coefficient from the mux; bits [24:0] used as signed Q4.20, bit 25 ignored.
- `y_out` output 25: y[n], signed Q4.20, held until the next result.
- `y_valid` output 1: one-cycle strobe when `y_out` updates.
- `busy` output 1: high while a sample is being processed.
- `overrun` output 1: one-cycle strobe when `sample_valid` arrives while busy.

## Operation
- Reset values:
  - `sel` = 3'b111.
  - `y_out` = 0; `y_valid` = 0; `busy` = 0; `overrun` = 0.
  - History x1, x2, y1, y2 = 0; accumulator = 0; FSM in IDLE.
- Coefficient map, fixed: sel 0 = a1, 1 = a2, 2 = b0, 3 = b1, 4 = b2, others → mux outputs 0.
- Equation: y[n] = b0·x[n] + b1·x1 + b2·x2 − a1·y1 − a2·y2.
- States:
  - IDLE:
    - `sample_valid` = 1: x0 ← `sample_in`, acc ← 0, cnt ← 0, go to MAC.
    - Else `clear` = 1: history ← 0, stay in IDLE.
    - `sample_valid` takes priority over `clear`.
  - MAC, 5 cycles, cnt 0..4: `sel` = cnt; operand is y1, y2, x0, x1, x2 for cnt 0..4 respectively.
    - cnt 0,1: acc ← acc − coef·operand.
    - cnt 2..4: acc ← acc + coef·operand.
    - After cnt = 4, go to DONE.
  - DONE:
    - r = acc >>> 20 (arithmetic shift, truncation toward −∞).
    - Saturate r: > 0x0FFFFFF → 0x0FFFFFF; < −2^24 → 0x1000000.
    - y_out ← r; y_valid ← 1.
    - x2 ← x1, x1 ← x0, y2 ← y1, y1 ← r (saturated value).
    - Go to IDLE.
- Arithmetic widths:
  - Each product is 50-bit signed Q8.40.
  - Accumulator is 53-bit signed; no intermediate overflow is possible.
- `sel` = 3'b111 in IDLE and DONE.
- `busy` = (state ≠ IDLE), registered with the state.
- `sample_valid` while busy: sample dropped, `overrun` pulses in the following cycle, processing continues unaffected.
- `clear` outside IDLE is ignored.
- `rst_n` low mid-operation: immediate return to reset values, history lost, no `y_valid`.

## Timing
- Edge E0 samples `sample_valid` = 1 in IDLE.
- `busy` high after E0 through E6.
- `sel` = 0..4 after edges E0..E4 (one value per cycle); product accumulated at E1..E5.
- DONE occupies the cycle after E5; at E6, `y_out`/history update and `y_valid` is set.
- `y_valid` is high for exactly the cycle after E6; `busy` is 0 in that same cycle.
- Latency: 7 cycles from accept edge to `y_valid` high.
- Throughput: a new `sample_valid` is accepted in the `y_valid` cycle, so one sample per 7 cycles maximum.
- `coef_in` is consumed combinationally in the cycle `sel` is presented; no pipeline register on the coefficient.

## Test plan
- Reset, then idle 10 cycles → `sel` = 3'b111, `y_out` = 0, `y_valid`/`busy`/`overrun` = 0 throughout.
- Impulse with the mux connected:
  - x = 0x0100000 then x = 0 → y[0] = 209 (0x00000D1).
  - y[1] = 826 (0x000033A).
  - Each `y_valid` exactly 7 cycles after its accept edge; `sel` sequence 0,1,2,3,4.
- Back-to-back: assert `sample_valid` in every `y_valid` cycle for 20 samples → every sample accepted, no `overrun`, outputs match a bit-exact Q4.20 floor-truncation reference model.
- Overrun: `sample_valid` 3 cycles after an accept → `overrun` one-cycle pulse; the in-flight result is unchanged; the dropped sample never appears in history.
- Saturation, bench-driven `coef_in` with b0 = 0x0F00000 (15.0) and all other coefficients 0:
  - x = 0x0FFFFFF → y = 0x0FFFFFF.
  - x = 0x1000000 → y = 0x1000000.
- Clear and reset:
  - `clear` in IDLE after the impulse response, then x = 0 → y = 0.
  - `rst_n` pulled low at the 3rd MAC cycle → all outputs return to reset values at once, no `y_valid`; the next impulse reproduces y[0] = 209.

Source files
------------

// File: rtl/iir_biquad_seq.sv
// Time-multiplexed direct-form-I biquad: one shared multiplier walks the five taps
// over five cycles, then floors to Q4.20, saturates and shifts the filter history.
module iir_biquad_seq #(
    parameter int DW   = 25,
    parameter int FRAC = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_valid,
    input  logic signed [DW-1:0] sample_in,
    input  logic                 clear,
    output logic [2:0]           sel,
    input  logic [DW:0]          coef_in,
    output logic signed [DW-1:0] y_out,
    output logic                 y_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int PW = 2 * DW;      // Q8.40 product
    localparam int AW = PW + 3;      // headroom for five products
    localparam int RW = AW - FRAC;   // accumulator after the fraction shift

    localparam logic signed [RW-1:0] SAT_HI = RW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] SAT_LO = RW'(-(64'sd1 <<< (DW - 1)));

    localparam logic [2:0] SEL_IDLE = 3'b111;
    localparam logic [2:0] CNT_LAST = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_e;

    state_e               state_q;
    logic [2:0]           cnt_q;
    logic [2:0]           sel_q;
    logic signed [DW-1:0] x0_q, x1_q, x2_q;
    logic signed [DW-1:0] y1_q, y2_q;
    logic signed [DW-1:0] y_out_q;
    logic signed [AW-1:0] acc_q;
    logic                 y_valid_q;
    logic                 busy_q;
    logic                 overrun_q;

    logic signed [DW-1:0] coef_s;
    logic signed [DW-1:0] opnd_d;
    logic signed [PW-1:0] prod_d;
    logic signed [AW-1:0] prod_ext_d;
    logic signed [AW-1:0] acc_d;
    logic signed [RW-1:0] res_d;
    logic signed [DW-1:0] y_sat_d;
    logic                 unused_coef_msb;

    // Bit DW of the mux output carries no meaning for this filter.
    assign coef_s          = coef_in[DW-1:0];
    assign unused_coef_msb = coef_in[DW];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        opnd_d = '0;
        case (cnt_q)
            3'd0:    opnd_d = y1_q;
            3'd1:    opnd_d = y2_q;
            3'd2:    opnd_d = x0_q;
            3'd3:    opnd_d = x1_q;
            3'd4:    opnd_d = x2_q;
            default: opnd_d = '0;
        endcase
    end

    assign prod_d     = PW'(coef_s) * PW'(opnd_d);
    assign prod_ext_d = {{(AW - PW){prod_d[PW-1]}}, prod_d};

    // Feedback taps (a1, a2) are subtracted, feed-forward taps added.
    always_comb begin
        acc_d = acc_q;
        if (cnt_q < 3'd2) begin
            acc_d = acc_q - prod_ext_d;
        end else begin
            acc_d = acc_q + prod_ext_d;
        end
    end

    assign res_d = RW'(acc_q >>> FRAC);

    always_comb begin
        y_sat_d = res_d[DW-1:0];
        if (res_d > SAT_HI) begin
            y_sat_d = SAT_HI[DW-1:0];
        end else if (res_d < SAT_LO) begin
            y_sat_d = SAT_LO[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: history and accumulator are reset too, so a reset mid-sample leaves no trace.
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_q     <= SEL_IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            acc_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values.
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sample_valid) begin
                        x0_q    <= sample_in;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sel_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_MAC;
                    end else if (clear) begin
                        x1_q <= '0;
                        x2_q <= '0;
                        y1_q <= '0;
                        y2_q <= '0;
                    end
                end

                S_MAC: begin
                    overrun_q <= sample_valid;
                    acc_q     <= acc_d;
                    if (cnt_q == CNT_LAST) begin
                        sel_q   <= SEL_IDLE;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                        sel_q <= cnt_q + 3'd1;
                    end
                end

                S_DONE: begin
                    overrun_q <= sample_valid;
                    y_out_q   <= y_sat_d;
                    y_valid_q <= 1'b1;
                    x2_q      <= x1_q;
                    x1_q      <= x0_q;
                    y2_q      <= y1_q;
                    y1_q      <= y_sat_d;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end

                default: begin
                    sel_q   <= SEL_IDLE;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sel     = sel_q;
    assign y_out   = y_out_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Bench for iir_biquad_seq: models the coefficient mux, keeps a transaction-level
// difference-equation reference, and drives directed impulse/overrun/saturation/reset cases.
module tb_iir_biquad_seq;

    localparam int DW = 25;
    localparam logic signed [DW-1:0] ONE = 25'sh0100000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 sample_valid;
    logic signed [DW-1:0] sample_in;
    logic                 clear;
    logic [2:0]           sel;
    logic [DW:0]          coef_in;
    logic signed [DW-1:0] y_out;
    logic                 y_valid;
    logic                 busy;
    logic                 overrun;

    bit                   sat_mode = 1'b0;
    logic [DW-1:0]        mux_c;
    int                   tests = 0;
    int                   fails = 0;

    // Reference state: filter history and the outstanding result timeline.
    longint m_x1 = 0, m_x2 = 0, m_y1 = 0, m_y2 = 0;
    longint m_px = 0, m_pend = 0, m_ey = 0;
    int     m_phase = 0;
    bit     m_yv = 1'b0, m_ovr = 1'b0;

    always #5 clk = ~clk;

    iir_biquad_seq #(.DW(DW), .FRAC(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .clear        (clear),
        .sel          (sel),
        .coef_in      (coef_in),
        .y_out        (y_out),
        .y_valid      (y_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    // 200 Hz low-pass constants (raw Q4.20), or the b0-only saturation set.
    function automatic longint coef_of(int s, bit sat);
        if (sat) return (s == 2) ? 64'sd15728640 : 64'sd0;
        case (s)
            0:       return -64'sd2049966;
            1:       return 64'sd1002226;
            2:       return 64'sd209;
            3:       return 64'sd418;
            4:       return 64'sd209;
            default: return 64'sd0;
        endcase
    endfunction

    // Mux model; bit 25 is driven to the wrong sign so any use of it shows up.
    always_comb begin
        mux_c   = DW'(coef_of(int'(sel), sat_mode));
        coef_in = {~mux_c[DW-1], mux_c};
    end

    function automatic longint biquad_ref(longint x0);
        longint acc;
        longint r;
        acc = coef_of(2, sat_mode) * x0 + coef_of(3, sat_mode) * m_x1
            + coef_of(4, sat_mode) * m_x2 - coef_of(0, sat_mode) * m_y1
            - coef_of(1, sat_mode) * m_y2;
        r = acc >>> 20;
        if (r > 64'sd16777215) r = 64'sd16777215;
        else if (r < -64'sd16777216) r = -64'sd16777216;
        return r;
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
        m_px = 0; m_pend = 0; m_ey = 0;
        m_phase = 0; m_yv = 1'b0; m_ovr = 1'b0;
    endtask

    // Reference timeline: result appears on the 6th edge after acceptance.
    initial begin : compare
        forever begin
            @(posedge clk);
            m_yv  = 1'b0;
            m_ovr = 1'b0;
            if (!rst_n) begin
                model_reset();
            end else if (m_phase == 0) begin
                if (sample_valid) begin
                    m_px    = longint'(sample_in);
                    m_pend  = biquad_ref(m_px);
                    m_phase = 1;
                end else if (clear) begin
                    m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
                end
            end else begin
                m_ovr = sample_valid;
                if (m_phase == 6) begin
                    m_x2 = m_x1; m_x1 = m_px;
                    m_y2 = m_y1; m_y1 = m_pend;
                    m_ey = m_pend; m_yv = 1'b1;
                    m_phase = 0;
                end else begin
                    m_phase++;
                end
            end
            @(negedge clk);
            if (!rst_n) model_reset();
            check("sel", sel, (m_phase >= 1 && m_phase <= 5) ? m_phase - 1 : 7);
            check("busy", busy, m_phase != 0);
            check("y_valid", y_valid, m_yv);
            check("overrun", overrun, m_ovr);
            check("y_out", y_out, m_ey);
        end
    end

    // Accept one sample and wait for its result; checks sel order and latency.
    task automatic send(input logic signed [DW-1:0] x, output logic signed [DW-1:0] y);
        int lat;
        lat = 0;
        y   = 'x;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = x;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) sample_valid = 1'b0;
            if (n <= 5) check("sel_seq", sel, n - 1);
            if (y_valid) begin
                lat = n;
                y   = y_out;
                break;
            end
        end
        check("latency", lat, 7);
    endtask

    function automatic logic signed [DW-1:0] b2b_vec(int i);
        return DW'(((i * 5) % 9 - 4) * 200000 + ((i % 2 == 1) ? 12345 : -6789));
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        logic signed [DW-1:0] y;
        int quiet, got, ovr, c_end, n;

        rst_n = 1'b1;
        sample_valid = 1'b0;
        clear = 1'b0;
        sample_in = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Idle after reset
        quiet = 0;
        repeat (10) begin
            @(negedge clk);
            if (y_valid || busy || overrun) quiet++;
        end
        check("rst_sel", sel, 7);
        check("rst_y_out", y_out, 0);
        check("rst_quiet", quiet, 0);

        // Impulse response
        send(ONE, y);
        check("impulse_y0", y, 209);
        send('0, y);
        check("impulse_y1", y, 826);

        // Clear in IDLE wipes history
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        send('0, y);
        check("clear_y", y, 0);

        // Overrun three cycles after accept; clear while busy is ignored
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = ONE;
        y = 'x;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            clear        = 1'b0;
            if (n == 3) begin
                sample_valid = 1'b1;
                sample_in    = 25'sh0FFFFFF;
                clear        = 1'b1;
            end
            if (n == 4) check("overrun_pulse", overrun, 1);
            if (n == 5) check("overrun_once", overrun, 0);
            if (y_valid) begin
                y = y_out;
                break;
            end
        end
        check("overrun_latency", n, 7);
        check("overrun_inflight_y", y, 209);
        send('0, y);
        check("overrun_history_y", y, 826);

        // Back-to-back: new sample in every y_valid cycle
        got = 0; ovr = 0; c_end = 0;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = b2b_vec(0);
        for (int c = 1; c <= 300 && got < 20; c++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (overrun) ovr++;
            if (y_valid) begin
                got++;
                c_end = c;
                if (got < 20) begin
                    sample_valid = 1'b1;
                    sample_in    = b2b_vec(got);
                end
            end
        end
        check("b2b_count", got, 20);
        check("b2b_overrun", ovr, 0);
        check("b2b_cycles", c_end, 140);

        // Saturation with b0 = 15.0 only
        @(negedge clk); sat_mode = 1'b1;
        send(25'sh0FFFFFF, y);
        check("sat_pos", y, 25'sh0FFFFFF);
        send(25'sh1000000, y);
        check("sat_neg", y, 25'sh1000000);
        send(25'sh0010000, y);
        check("sat_none", y, 25'sh00F0000);
        @(negedge clk); sat_mode = 1'b0;

        // Reset during the third MAC cycle
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = ONE;
        @(negedge clk);
        sample_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("pre_reset_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_sel", sel, 7);
        check("mid_rst_y_out", y_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_y_valid", y_valid, 0);
        check("mid_rst_overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        quiet = 0;
        repeat (10) begin
            @(negedge clk);
            if (y_valid) quiet++;
        end
        check("post_rst_no_valid", quiet, 0);
        send(ONE, y);
        check("post_rst_y0", y, 209);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
